// File: rtl/i2s_pkg.sv
// Shared definitions for the I2S/TDM debug receive path: sine test pattern,
// slot limits and the receive/checker state encodings.
package i2s_pkg;

    localparam int TDM_SLOTS_MAX = 32;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_DELAY = 2'd1,
        RX_SHIFT = 2'd2,
        RX_DONE  = 2'd3
    } rx_state_e;

    typedef enum logic [1:0] {
        CK_UNLOCKED = 2'd0,
        CK_PRIME    = 2'd1,
        CK_LOCKED   = 2'd2
    } ck_state_e;

    // 16-entry sine pattern emitted by the debug data-out generator
    function automatic logic [31:0] sine_entry(input logic [3:0] idx);
        logic [31:0] val;
        case (idx)
            4'd0:    val = 32'h0000_0000;
            4'd1:    val = 32'h30FB_C550;
            4'd2:    val = 32'h5A82_79A0;
            4'd3:    val = 32'h7641_AF40;
            4'd4:    val = 32'h7FFF_FFFF;
            4'd5:    val = 32'h7641_AF40;
            4'd6:    val = 32'h5A82_79A0;
            4'd7:    val = 32'h30FB_C550;
            4'd8:    val = 32'h0000_0000;
            4'd9:    val = 32'hCF04_3AB0;
            4'd10:   val = 32'hA57D_8660;
            4'd11:   val = 32'h89BE_50C0;
            4'd12:   val = 32'h8000_0000;
            4'd13:   val = 32'h89BE_50C0;
            4'd14:   val = 32'hA57D_8660;
            4'd15:   val = 32'hCF04_3AB0;
            default: val = 32'h0000_0000;
        endcase
        return val;
    endfunction

endpackage

// File: rtl/i2s_tdm_rx_checker_if.sv
// Serial input pins and recovered-word/status outputs of the TDM receiver.
interface i2s_tdm_rx_checker_if;
    import i2s_pkg::*;

    logic        lrck;
    logic        datai;
    logic [4:0]  tdm_num;
    logic [31:0] word;
    logic        word_valid;
    logic [4:0]  slot;
    logic        short_err;
    logic        locked;
    logic        mism;
    logic [15:0] err_count;

    modport master (
        output lrck, datai, tdm_num,
        input  word, word_valid, slot, short_err, locked, mism, err_count
    );

    modport slave (
        input  lrck, datai, tdm_num,
        output word, word_valid, slot, short_err, locked, mism, err_count
    );

endinterface

// File: rtl/i2s_tdm_deser.sv
// lrck slot-start detection, serial-to-parallel receive FSM and slot counter.
// All outputs are registered; word/slot hold until the next word_valid.
module i2s_tdm_deser
    import i2s_pkg::*;
#(
    parameter int BIT_DELAY = 0
) (
    input  logic        bclk,
    input  logic        srst,
    input  logic        lrck,
    input  logic        datai,
    input  logic [4:0]  tdm_num,
    output logic [31:0] word,
    output logic        word_valid,
    output logic [4:0]  slot,
    output logic        short_err,
    output logic        frame_last
);

    rx_state_e   rx_state_q, rx_state_d;
    logic        lrck_q, lrck_d;
    logic [31:0] shreg_q, shreg_d;
    logic [5:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  dly_q, dly_d;
    logic [4:0]  slot_cnt_q, slot_cnt_d;
    logic [5:0]  tdm_act_q, tdm_act_d;
    logic        first_q, first_d;
    logic [31:0] word_q, word_d;
    logic        word_valid_q, word_valid_d;
    logic [4:0]  slot_q, slot_d;
    logic        short_err_q, short_err_d;
    logic        frame_last_q, frame_last_d;

    logic        slot_start_s;
    logic [5:0]  tdm_eff_s;
    logic [5:0]  slot_inc_s;

    // Next-state logic for receive FSM, slot counter and output registers
    always_comb begin
        rx_state_d   = rx_state_q;
        lrck_d       = lrck;
        shreg_d      = shreg_q;
        bit_cnt_d    = bit_cnt_q;
        dly_d        = dly_q;
        slot_cnt_d   = slot_cnt_q;
        tdm_act_d    = tdm_act_q;
        first_d      = first_q;
        word_d       = word_q;
        word_valid_d = 1'b0;
        slot_d       = slot_q;
        short_err_d  = 1'b0;
        frame_last_d = frame_last_q;

        slot_start_s = ~lrck & lrck_q;
        tdm_eff_s    = (tdm_num == 5'd0) ? 6'(TDM_SLOTS_MAX) : {1'b0, tdm_num};
        slot_inc_s   = {1'b0, slot_cnt_q} + 6'd1;

        if (slot_start_s) begin
            // SHIFT only ever holds 1..31 collected bits, so any restart here is a cut slot
            if (rx_state_q == RX_SHIFT) begin
                short_err_d = 1'b1;
            end else begin
                short_err_d = 1'b0;
            end
            // tdm_num is only adopted at a wrap so a frame never changes length midway
            if (first_q) begin
                slot_cnt_d = 5'd0;
                tdm_act_d  = tdm_eff_s;
                first_d    = 1'b0;
            end else if (slot_inc_s >= tdm_act_q) begin
                slot_cnt_d = 5'd0;
                tdm_act_d  = tdm_eff_s;
            end else begin
                slot_cnt_d = slot_inc_s[4:0];
            end
            if (BIT_DELAY == 0) begin
                rx_state_d = RX_SHIFT;
                shreg_d    = {31'd0, datai};
                bit_cnt_d  = 6'd1;
            end else begin
                rx_state_d = RX_DELAY;
                dly_d      = 8'(BIT_DELAY);
                bit_cnt_d  = 6'd0;
            end
        end else begin
            case (rx_state_q)
                RX_IDLE: begin
                    rx_state_d = RX_IDLE;
                end
                RX_DELAY: begin
                    if (dly_q <= 8'd1) begin
                        rx_state_d = RX_SHIFT;
                        shreg_d    = {31'd0, datai};
                        bit_cnt_d  = 6'd1;
                    end else begin
                        dly_d = dly_q - 8'd1;
                    end
                end
                RX_SHIFT: begin
                    shreg_d   = {shreg_q[30:0], datai};
                    bit_cnt_d = bit_cnt_q + 6'd1;
                    if (bit_cnt_q == 6'd31) begin
                        rx_state_d   = RX_DONE;
                        word_d       = {shreg_q[30:0], datai};
                        word_valid_d = 1'b1;
                        slot_d       = slot_cnt_q;
                        frame_last_d = (slot_inc_s >= tdm_act_q);
                    end else begin
                        rx_state_d = RX_SHIFT;
                    end
                end
                RX_DONE: begin
                    rx_state_d = RX_DONE;
                end
                default: begin
                    rx_state_d = RX_IDLE;
                end
            endcase
        end
    end

    // State and output registers with synchronous reset
    always_ff @(posedge bclk) begin
        if (srst) begin
            rx_state_q   <= RX_IDLE;
            lrck_q       <= 1'b1;
            shreg_q      <= 32'd0;
            bit_cnt_q    <= 6'd0;
            dly_q        <= 8'd0;
            slot_cnt_q   <= 5'd0;
            tdm_act_q    <= 6'(TDM_SLOTS_MAX);
            first_q      <= 1'b1;
            word_q       <= 32'd0;
            word_valid_q <= 1'b0;
            slot_q       <= 5'd0;
            short_err_q  <= 1'b0;
            frame_last_q <= 1'b0;
        end else begin
            rx_state_q   <= rx_state_d;
            lrck_q       <= lrck_d;
            shreg_q      <= shreg_d;
            bit_cnt_q    <= bit_cnt_d;
            dly_q        <= dly_d;
            slot_cnt_q   <= slot_cnt_d;
            tdm_act_q    <= tdm_act_d;
            first_q      <= first_d;
            word_q       <= word_d;
            word_valid_q <= word_valid_d;
            slot_q       <= slot_d;
            short_err_q  <= short_err_d;
            frame_last_q <= frame_last_d;
        end
    end

    assign word       = word_q;
    assign word_valid = word_valid_q;
    assign slot       = slot_q;
    assign short_err  = short_err_q;
    assign frame_last = frame_last_q;

endmodule

// File: rtl/i2s_tdm_rx_checker.sv
// TDM receiver plus sine-pattern checker: locks onto the generator's table
// position from two consecutive slot-0 words, then counts mismatching words.
module i2s_tdm_rx_checker
    import i2s_pkg::*;
#(
    parameter int BIT_DELAY   = 0,
    parameter int LOSS_FRAMES = 4
) (
    input  logic                  bclk,
    input  logic                  srst,
    i2s_tdm_rx_checker_if.slave   bus
);

    logic [31:0] word_s;
    logic        word_valid_s;
    logic [4:0]  slot_s;
    logic        short_err_s;
    logic        frame_last_s;

    i2s_tdm_deser #(
        .BIT_DELAY (BIT_DELAY)
    ) u_deser (
        .bclk       (bclk),
        .srst       (srst),
        .lrck       (bus.lrck),
        .datai      (bus.datai),
        .tdm_num    (bus.tdm_num),
        .word       (word_s),
        .word_valid (word_valid_s),
        .slot       (slot_s),
        .short_err  (short_err_s),
        .frame_last (frame_last_s)
    );

    ck_state_e   ck_state_q, ck_state_d;
    logic [31:0] prev_q, prev_d;
    logic [3:0]  idx_q, idx_d;
    logic [7:0]  bad_cnt_q, bad_cnt_d;
    logic        frame_bad_q, frame_bad_d;
    logic        locked_q, locked_d;
    logic        mism_q, mism_d;
    logic [15:0] err_count_q, err_count_d;

    logic        slot0_s;
    logic        found_s;
    logic [3:0]  found_idx_s;
    logic        hit_s;
    logic [3:0]  exp_idx_s;
    logic        miss_s;
    logic        bad_now_s;
    logic [7:0]  bad_inc_s;

    // Pattern search, checker FSM next state and error accounting
    always_comb begin
        ck_state_d  = ck_state_q;
        prev_d      = prev_q;
        idx_d       = idx_q;
        bad_cnt_d   = bad_cnt_q;
        frame_bad_d = frame_bad_q;
        locked_d    = locked_q;
        mism_d      = 1'b0;
        err_count_d = err_count_q;

        slot0_s     = word_valid_s & (slot_s == 5'd0);
        found_s     = 1'b0;
        found_idx_s = 4'd0;
        hit_s       = 1'b0;
        // Single values repeat in the table but each (prev, cur) pair is unique
        for (int i = 0; i < 16; i++) begin
            hit_s       = (sine_entry(4'(i)) == prev_q) && (sine_entry(4'(i + 1)) == word_s);
            found_s     = found_s | hit_s;
            found_idx_s = hit_s ? 4'(i + 1) : found_idx_s;
        end

        exp_idx_s = (slot_s == 5'd0) ? (idx_q + 4'd1) : idx_q;
        miss_s    = (word_s != sine_entry(exp_idx_s));
        bad_now_s = ((slot_s == 5'd0) ? 1'b0 : frame_bad_q) | miss_s;
        bad_inc_s = bad_cnt_q + 8'd1;

        case (ck_state_q)
            CK_UNLOCKED: begin
                if (slot0_s) begin
                    prev_d     = word_s;
                    ck_state_d = CK_PRIME;
                end else begin
                    ck_state_d = CK_UNLOCKED;
                end
            end
            CK_PRIME: begin
                if (slot0_s && found_s) begin
                    idx_d       = found_idx_s;
                    ck_state_d  = CK_LOCKED;
                    locked_d    = 1'b1;
                    bad_cnt_d   = 8'd0;
                    frame_bad_d = 1'b0;
                end else if (slot0_s) begin
                    prev_d = word_s;
                end else begin
                    ck_state_d = CK_PRIME;
                end
            end
            CK_LOCKED: begin
                if (word_valid_s) begin
                    idx_d  = exp_idx_s;
                    mism_d = miss_s;
                    if (miss_s && (err_count_q != 16'hFFFF)) begin
                        err_count_d = err_count_q + 16'd1;
                    end else begin
                        err_count_d = err_count_q;
                    end
                    if (frame_last_s && bad_now_s && (bad_inc_s >= 8'(LOSS_FRAMES))) begin
                        ck_state_d  = CK_UNLOCKED;
                        locked_d    = 1'b0;
                        bad_cnt_d   = 8'd0;
                        frame_bad_d = 1'b0;
                    end else if (frame_last_s && bad_now_s) begin
                        bad_cnt_d   = bad_inc_s;
                        frame_bad_d = 1'b0;
                    end else if (frame_last_s) begin
                        bad_cnt_d   = 8'd0;
                        frame_bad_d = 1'b0;
                    end else begin
                        frame_bad_d = bad_now_s;
                    end
                end else begin
                    ck_state_d = CK_LOCKED;
                end
            end
            default: begin
                ck_state_d = CK_UNLOCKED;
                locked_d   = 1'b0;
            end
        endcase
    end

    // Checker registers; err_count is cleared only here by srst
    always_ff @(posedge bclk) begin
        if (srst) begin
            ck_state_q  <= CK_UNLOCKED;
            prev_q      <= 32'd0;
            idx_q       <= 4'd0;
            bad_cnt_q   <= 8'd0;
            frame_bad_q <= 1'b0;
            locked_q    <= 1'b0;
            mism_q      <= 1'b0;
            err_count_q <= 16'd0;
        end else begin
            ck_state_q  <= ck_state_d;
            prev_q      <= prev_d;
            idx_q       <= idx_d;
            bad_cnt_q   <= bad_cnt_d;
            frame_bad_q <= frame_bad_d;
            locked_q    <= locked_d;
            mism_q      <= mism_d;
            err_count_q <= err_count_d;
        end
    end

    assign bus.word       = word_s;
    assign bus.word_valid = word_valid_s;
    assign bus.slot       = slot_s;
    assign bus.short_err  = short_err_s;
    assign bus.locked     = locked_q;
    assign bus.mism       = mism_q;
    assign bus.err_count  = err_count_q;

endmodule

// File: tb/tb_i2s_tdm_rx_checker.sv
// Bench for i2s_tdm_rx_checker: a local sine-pattern generator drives the pins
// and pushes expected (word, slot) pairs; a monitor pops and compares them.
module tb_i2s_tdm_rx_checker;

    typedef struct {
        logic [31:0] w;
        logic [4:0]  s;
    } exp_t;

    logic bclk;
    logic srst;
    int   errors;
    int   checks;
    exp_t exp_q[$];
    exp_t mon_e;

    int   tdm_n;
    int   exp_slot;
    int   cyc;
    int   wv_cnt;
    int   last_wv_cyc;
    int   mism_cnt;
    int   mism_delay;
    int   short_cnt;
    int   lock_rise_wv;
    int   lock_rise_delay;
    logic locked_prev;

    i2s_tdm_rx_checker_if bus ();

    i2s_tdm_rx_checker #(
        .BIT_DELAY   (0),
        .LOSS_FRAMES (4)
    ) dut (
        .bclk (bclk),
        .srst (srst),
        .bus  (bus)
    );

    initial bclk = 1'b0;
    always #5 bclk = ~bclk;

    function automatic logic [31:0] pat(input int i);
        logic [31:0] v;
        case (i % 16)
            0:       v = 32'h0000_0000;
            1:       v = 32'h30FB_C550;
            2:       v = 32'h5A82_79A0;
            3:       v = 32'h7641_AF40;
            4:       v = 32'h7FFF_FFFF;
            5:       v = 32'h7641_AF40;
            6:       v = 32'h5A82_79A0;
            7:       v = 32'h30FB_C550;
            8:       v = 32'h0000_0000;
            9:       v = 32'hCF04_3AB0;
            10:      v = 32'hA57D_8660;
            11:      v = 32'h89BE_50C0;
            12:      v = 32'h8000_0000;
            13:      v = 32'h89BE_50C0;
            14:      v = 32'hA57D_8660;
            default: v = 32'hCF04_3AB0;
        endcase
        return v;
    endfunction

    // Monitor: scoreboard pop on word_valid, pulse counters, lock-rise timing
    always @(posedge bclk) begin
        #1;
        cyc = cyc + 1;
        if (bus.word_valid === 1'b1) begin
            wv_cnt      = wv_cnt + 1;
            last_wv_cyc = cyc;
            if (exp_q.size() == 0) begin
                checks = checks + 1;
                errors = errors + 1;
                $display("FAIL unexpected_word got=%h slot=%0d exp=none", bus.word, bus.slot);
            end else begin
                mon_e  = exp_q.pop_front();
                checks = checks + 1;
                if (bus.word !== mon_e.w) begin
                    errors = errors + 1;
                    $display("FAIL word_data got=%h exp=%h", bus.word, mon_e.w);
                end
                checks = checks + 1;
                if (bus.slot !== mon_e.s) begin
                    errors = errors + 1;
                    $display("FAIL word_slot got=%0d exp=%0d", bus.slot, mon_e.s);
                end
            end
        end
        if (bus.mism === 1'b1) begin
            mism_cnt   = mism_cnt + 1;
            mism_delay = cyc - last_wv_cyc;
        end
        if (bus.short_err === 1'b1) short_cnt = short_cnt + 1;
        if (bus.locked === 1'b1 && locked_prev !== 1'b1) begin
            lock_rise_wv    = wv_cnt;
            lock_rise_delay = cyc - last_wv_cyc;
        end
        locked_prev = bus.locked;
    end

    task automatic do_reset(input int n);
        tdm_n = n;
        bus.tdm_num = 5'(n);
        @(negedge bclk);
        srst      = 1'b1;
        bus.lrck  = 1'b1;
        bus.datai = 1'b0;
        @(negedge bclk);
        @(negedge bclk);
        srst = 1'b0;
        exp_slot = 0;
        exp_q.delete();
        wv_cnt = 0;
        mism_cnt = 0;
        mism_delay = -1;
        short_cnt = 0;
        lock_rise_wv = -1;
        lock_rise_delay = -1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge bclk);
            bus.lrck  = 1'b1;
            bus.datai = 1'b0;
        end
    endtask

    // One slot: lrck low on the first bit only; optional srst pulse at bit rst_bit
    task automatic send_slot(input logic [31:0] w, input int nbits, input int rst_bit);
        logic [4:0] s;
        s = 5'(exp_slot);
        exp_slot = (exp_slot + 1) % tdm_n;
        for (int b = 0; b < nbits; b++) begin
            @(negedge bclk);
            if (rst_bit >= 0 && b == rst_bit + 1) begin
                checks = checks + 7;
                if (bus.word !== 32'd0)      begin errors++; $display("FAIL srst_word got=%h exp=0", bus.word); end
                if (bus.word_valid !== 1'b0) begin errors++; $display("FAIL srst_wv got=%b exp=0", bus.word_valid); end
                if (bus.slot !== 5'd0)       begin errors++; $display("FAIL srst_slot got=%0d exp=0", bus.slot); end
                if (bus.short_err !== 1'b0)  begin errors++; $display("FAIL srst_short got=%b exp=0", bus.short_err); end
                if (bus.locked !== 1'b0)     begin errors++; $display("FAIL srst_locked got=%b exp=0", bus.locked); end
                if (bus.mism !== 1'b0)       begin errors++; $display("FAIL srst_mism got=%b exp=0", bus.mism); end
                if (bus.err_count !== 16'd0) begin errors++; $display("FAIL srst_err got=%0d exp=0", bus.err_count); end
                srst = 1'b0;
            end
            bus.lrck  = (b == 0) ? 1'b0 : 1'b1;
            bus.datai = w[31 - b];
            if (b == rst_bit) begin
                srst = 1'b1;
                exp_slot = 0;
            end
        end
        if (nbits == 32 && rst_bit < 0) exp_q.push_back('{w, s});
    endtask

    task automatic send_frame(input int f, input logic zero, input logic [31:0] flip,
                              input int flip_slot, input int short_slot);
        logic [31:0] w;
        for (int s = 0; s < tdm_n; s++) begin
            w = zero ? 32'd0 : pat(f);
            if (s == flip_slot) w = w ^ flip;
            send_slot(w, (s == short_slot) ? 20 : 32, -1);
        end
    endtask

    task automatic check_drained(input string name, input int exp_wv);
        checks = checks + 1;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_pending got=%0d exp=0", name, exp_q.size());
        end
        checks = checks + 1;
        if (wv_cnt != exp_wv) begin
            errors++;
            $display("FAIL %s_wv_count got=%0d exp=%0d", name, wv_cnt, exp_wv);
        end
    endtask

    task automatic test_reset();
        do_reset(4);
        checks = checks + 4;
        if (bus.word !== 32'd0)      begin errors++; $display("FAIL rst_word got=%h exp=0", bus.word); end
        if (bus.word_valid !== 1'b0) begin errors++; $display("FAIL rst_wv got=%b exp=0", bus.word_valid); end
        if (bus.locked !== 1'b0)     begin errors++; $display("FAIL rst_locked got=%b exp=0", bus.locked); end
        if (bus.err_count !== 16'd0) begin errors++; $display("FAIL rst_err got=%0d exp=0", bus.err_count); end
    endtask

    task automatic test_basic();
        do_reset(4);
        for (int f = 0; f < 8; f++) send_frame(f, 1'b0, 32'd0, -1, -1);
        idle(4);
        check_drained("basic", 32);
        checks = checks + 5;
        if (lock_rise_wv != 5)     begin errors++; $display("FAIL basic_lock_word got=%0d exp=5", lock_rise_wv); end
        if (lock_rise_delay != 1)  begin errors++; $display("FAIL basic_lock_delay got=%0d exp=1", lock_rise_delay); end
        if (bus.locked !== 1'b1)   begin errors++; $display("FAIL basic_locked got=%b exp=1", bus.locked); end
        if (bus.err_count !== 16'd0) begin errors++; $display("FAIL basic_err got=%0d exp=0", bus.err_count); end
        if (mism_cnt != 0)         begin errors++; $display("FAIL basic_mism got=%0d exp=0", mism_cnt); end
    endtask

    task automatic test_tdm32();
        do_reset(32);
        bus.tdm_num = 5'd0;
        for (int f = 0; f < 3; f++) send_frame(f, 1'b0, 32'd0, -1, -1);
        idle(4);
        check_drained("tdm32", 96);
        checks = checks + 2;
        if (bus.locked !== 1'b1)     begin errors++; $display("FAIL tdm32_locked got=%b exp=1", bus.locked); end
        if (bus.err_count !== 16'd0) begin errors++; $display("FAIL tdm32_err got=%0d exp=0", bus.err_count); end
    endtask

    task automatic test_bitflip();
        do_reset(4);
        for (int f = 0; f < 8; f++)
            send_frame(f, 1'b0, (f == 5) ? 32'h0000_0080 : 32'd0, (f == 5) ? 2 : -1, -1);
        idle(4);
        check_drained("flip", 32);
        checks = checks + 4;
        if (mism_cnt != 1)           begin errors++; $display("FAIL flip_mism got=%0d exp=1", mism_cnt); end
        if (mism_delay != 1)         begin errors++; $display("FAIL flip_mism_delay got=%0d exp=1", mism_delay); end
        if (bus.err_count !== 16'd1) begin errors++; $display("FAIL flip_err got=%0d exp=1", bus.err_count); end
        if (bus.locked !== 1'b1)     begin errors++; $display("FAIL flip_locked got=%b exp=1", bus.locked); end
    endtask

    task automatic test_data_zero();
        do_reset(2);
        for (int f = 0; f < 7; f++) send_frame(f, (f >= 4), 32'd0, -1, -1);
        idle(3);
        checks = checks + 1;
        if (bus.locked !== 1'b1) begin errors++; $display("FAIL zero_locked_f6 got=%b exp=1", bus.locked); end
        send_frame(7, 1'b1, 32'd0, -1, -1);
        idle(3);
        checks = checks + 3;
        if (bus.locked !== 1'b0)     begin errors++; $display("FAIL zero_unlock got=%b exp=0", bus.locked); end
        if (bus.err_count !== 16'd8) begin errors++; $display("FAIL zero_err got=%0d exp=8", bus.err_count); end
        if (mism_cnt != 8)           begin errors++; $display("FAIL zero_mism got=%0d exp=8", mism_cnt); end
        send_frame(8, 1'b0, 32'd0, -1, -1);
        send_frame(9, 1'b0, 32'd0, -1, -1);
        idle(3);
        check_drained("zero", 20);
        checks = checks + 2;
        if (bus.locked !== 1'b1)     begin errors++; $display("FAIL zero_relock got=%b exp=1", bus.locked); end
        if (bus.err_count !== 16'd8) begin errors++; $display("FAIL zero_err_after got=%0d exp=8", bus.err_count); end
    endtask

    task automatic test_short();
        do_reset(4);
        send_frame(0, 1'b0, 32'd0, -1, 1);
        send_frame(1, 1'b0, 32'd0, -1, -1);
        send_frame(2, 1'b0, 32'd0, -1, -1);
        idle(4);
        check_drained("short", 11);
        checks = checks + 3;
        if (short_cnt != 1)          begin errors++; $display("FAIL short_pulse got=%0d exp=1", short_cnt); end
        if (bus.locked !== 1'b1)     begin errors++; $display("FAIL short_locked got=%b exp=1", bus.locked); end
        if (bus.err_count !== 16'd0) begin errors++; $display("FAIL short_err got=%0d exp=0", bus.err_count); end
    endtask

    task automatic test_srst_mid();
        do_reset(4);
        send_frame(0, 1'b0, 32'd0, -1, -1);
        send_frame(1, 1'b0, 32'd0, -1, -1);
        send_slot(pat(2), 32, -1);
        send_slot(pat(2), 32, 10);
        wv_cnt = 0;
        send_slot(pat(2), 32, -1);
        send_slot(pat(2), 32, -1);
        send_frame(3, 1'b0, 32'd0, -1, -1);
        idle(4);
        check_drained("srst_mid", 6);
        checks = checks + 1;
        if (short_cnt != 0) begin errors++; $display("FAIL srst_mid_short got=%0d exp=0", short_cnt); end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        cyc = 0;
        last_wv_cyc = 0;
        locked_prev = 1'b0;
        srst = 1'b1;
        bus.lrck = 1'b1;
        bus.datai = 1'b0;
        bus.tdm_num = 5'd4;
        tdm_n = 4;
        exp_slot = 0;
        test_reset();
        test_basic();
        test_tdm32();
        test_bitflip();
        test_data_zero();
        test_short();
        test_srst_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/i2s_tdm_rx_checker.md
# i2s_tdm_rx_checker

Serial-to-parallel TDM receiver and pattern checker for the I2S debug path. It samples the serial data pin against bclk/lrck and recovers one 32-bit word per slot. It checks the recovered stream against the 16-entry sine test pattern emitted by the debug data-out generator. It sits directly downstream of that generator, in loopback or on the far end of the link, and exposes words, lock state and error counts for ILA or register readout.

## Interface
Parameters:
- BIT_DELAY, 0: number of bclk periods between a slot-start detection and the MSB (0 for the debug generator, 1 for standard I2S).
- LOSS_FRAMES, 4: consecutive mismatching frames that drop lock.

Ports:
- bclk  in  1  bit clock; all logic on rising edge.
- srst  in  1  reset, synchronous, active-high.
- lrck  in  1  slot strobe; a falling edge marks a slot start.
- datai  in  1  serial data, MSB first, driven on falling bclk.
- tdm_num  in  5  slots per frame; 0 means 32.
- word  out  32  last complete slot word.
- word_valid  out  1  one-cycle pulse, word/slot valid.
- slot  out  5  slot index of word.
- short_err  out  1  one-cycle pulse, slot cut short.
- locked  out  1  checker locked to the pattern.
- mism  out  1  one-cycle pulse, word differs from expected.
- err_count  out  16  saturating mismatch count; cleared only by srst.

## Operation
- lrck is registered on every rising edge as lrck_q. Slot start: lrck==0 && lrck_q==1. lrck_q resets to 1.
- Receive FSM:
  - IDLE: wait for slot start.
  - DELAY: skip BIT_DELAY bits.
  - SHIFT: shift datai into bit 0, MSB first. Collect 32 bits, then go to DONE.
  - DONE: ignore further bits until the next slot start.
  - A slot start in any state restarts DELAY/SHIFT. With BIT_DELAY=0, the bit sampled on the start edge is the MSB.
- A slot start in SHIFT with 1..31 bits collected pulses short_err and discards the partial word. slot still advances.
- Slot counter:
  - Resets to 0 and increments modulo tdm_num on each slot start after the first.
  - The first slot after srst is slot 0. Frame alignment relies on the transmitter sharing srst.
- Pattern table, index 0..15: 00000000, 30FBC550, 5A8279A0, 7641AF40, 7FFFFFFF, 7641AF40, 5A8279A0, 30FBC550, 00000000, CF043AB0, A57D8660, 89BE50C0, 80000000, 89BE50C0, A57D8660, CF043AB0.
- Every slot of a frame carries the same entry. The index advances by 1 (mod 16) per frame.
- Checker FSM:
  - UNLOCKED: latch the slot-0 word as prev, then go to PRIME.
  - PRIME: on the next slot-0 word cur, search for the unique i with table[i]==prev and table[i+1 mod 16]==cur. The pair is unique even though single values repeat.
    - Found: idx=i+1, go to LOCKED.
    - Not found: prev=cur, stay in PRIME.
  - LOCKED:
    - Compare each word against table[idx]. Any inequality pulses mism and increments err_count (saturates at FFFF).
    - At each slot-0 word after the first, idx increments before the compare.
    - A frame containing at least one mismatch counts as bad. LOSS_FRAMES consecutive bad frames → UNLOCKED. A clean frame clears the bad-frame counter.
- mism and err_count are active only in LOCKED.

## Timing
- Reset values:
  - word=0, word_valid=0, slot=0, short_err=0, locked=0, mism=0, err_count=0.
  - FSMs in IDLE and UNLOCKED.
- srst mid-slot: the partial word is lost with no pulses. The next slot start begins slot 0.
- word_valid asserts on the rising edge after the 32nd bit is sampled, so latency is 1 bclk. word and slot stay stable until the next word_valid.
- Checker output: mism is registered one cycle after word_valid. locked rises the cycle after the PRIME match and falls the cycle after the LOSS_FRAMES-th bad frame completes.
- Frame end = word_valid for slot tdm_num-1 (31 when tdm_num=0).
- tdm_num is sampled at each slot start. A change takes effect at the next wrap.

## Structure
- Shared package i2s_pkg:
  - 16×32 pattern table constant.
  - TDM_SLOTS_MAX=32.
  - Receive and checker FSM state enums.
- One sub-module is natural: i2s_tdm_deser (lrck edge detect, receive FSM, slot counter). The checker FSM stays in the top.

## Test plan
- tdm_num=4, BIT_DELAY=0, generator driving 8 frames from srst → word_valid ×32. Slot sequence 0,1,2,3 repeating. Frame 0 words = 00000000, frame 1 = 30FBC550. locked=1 after frame 1 slot 0. err_count=0.
- tdm_num=0 → slot wraps 31→0. 32 words per frame.
- Locked, one bit flipped in frame 5 slot 2 → single mism pulse, err_count=1, locked stays 1.
- Locked, datai forced to 0 for 4 frames (tdm_num=2) → err_count=8 (entries 0 and 8, equal to 00000000, do not mismatch; count accordingly). locked falls after the 4th consecutive bad frame. Relock within 2 frames after release.
- lrck falling after 20 bits → short_err pulse, no word_valid for that slot, next slot received intact.
- srst asserted at bit 10 of slot 1 → all outputs return to reset values the next cycle. The next slot is reported as slot 0.
